// File: rtl/ffs_free_list.sv
// ffs_free_list
//   Bitmap free-list allocator built on find-first-set. Each cycle it offers
//   the NUM_ALLOC lowest-index free entries. It accepts pops of any offered
//   subset, and it takes back up to NUM_FREE entries. Offers are derived from
//   registered state only, so there is no combinational path from any input
//   to any output.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   alloc_valid  [NUM_ALLOC]       offer k holds a free entry
//   alloc_idx    [NUM_ALLOC*LG_N]  offer k at [k*LG_N +: LG_N]; 0 when invalid
//   alloc_pop    [NUM_ALLOC]       consume offer k this cycle
//   free_valid   [NUM_FREE]        return free_idx port j this cycle
//   free_idx     [NUM_FREE*LG_N]   returned index, port j at [j*LG_N +: LG_N]
//   free_count   [LG_N+1]          number of free entries (registered)
//   empty        free_count == 0
//   err          sticky protocol-error flag
module ffs_free_list #(
    parameter int LG_N         = 6,
    parameter int NUM_ALLOC    = 2,
    parameter int NUM_FREE     = 2,
    parameter int NUM_RESERVED = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [NUM_ALLOC-1:0]      alloc_valid,
    output logic [NUM_ALLOC*LG_N-1:0] alloc_idx,
    input  logic [NUM_ALLOC-1:0]      alloc_pop,
    input  logic [NUM_FREE-1:0]       free_valid,
    input  logic [NUM_FREE*LG_N-1:0]  free_idx,
    output logic [LG_N:0]             free_count,
    output logic                      empty,
    output logic                      err
);

    localparam int unsigned N = 1 << LG_N;

    function automatic logic [N-1:0] f_reset_map();
        logic [N-1:0] m;
        for (int unsigned i = 0; i < N; i++) begin
            m[i] = (i >= int'(NUM_RESERVED)) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    localparam logic [N-1:0] RESET_MAP = f_reset_map();
    localparam logic [LG_N:0] RESET_CNT = (LG_N+1)'(N - NUM_RESERVED);

    logic [N-1:0]    r_bitmap;
    logic [LG_N:0]   r_count;
    logic            r_err;

    logic [LG_N-1:0] w_idx [NUM_ALLOC];
    logic [NUM_ALLOC-1:0] w_valid;
    logic [N-1:0]    w_popmask;
    logic [N-1:0]    w_freemask;
    logic [N-1:0]    w_next;
    logic [LG_N:0]   w_next_cnt;
    logic            w_err_evt;

    // Offer k is the lowest set bit left after masking the bits that
    // earlier offers took.
    always_comb begin : offer
        logic [N-1:0] rem;
        logic         found;
        rem     = r_bitmap;
        w_valid = '0;
        for (int unsigned k = 0; k < NUM_ALLOC; k++) begin
            w_idx[k] = '0;
            found    = 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && rem[i]) begin
                    w_idx[k] = LG_N'(i);
                    found    = 1'b1;
                end
            end
            w_valid[k] = found;
            if (found) rem[w_idx[k]] = 1'b0;
        end
    end

    always_comb begin : pack
        alloc_idx = '0;
        for (int unsigned k = 0; k < NUM_ALLOC; k++) begin
            alloc_idx[k*LG_N +: LG_N] = w_idx[k];
        end
    end

    assign alloc_valid = w_valid;
    assign free_count  = r_count;
    assign empty       = (r_count == '0);
    assign err         = r_err;

    always_comb begin : next_state
        logic [LG_N-1:0] fi;
        w_popmask  = '0;
        w_freemask = '0;
        w_err_evt  = 1'b0;
        fi         = '0;
        for (int unsigned k = 0; k < NUM_ALLOC; k++) begin
            if (alloc_pop[k]) begin
                if (w_valid[k]) w_popmask[w_idx[k]] = 1'b1;
                else            w_err_evt = 1'b1;
            end
        end
        // The earlier-port mask check detects duplicate indices across
        // ports. An index that is popped in the same cycle is a legal recycle.
        for (int unsigned j = 0; j < NUM_FREE; j++) begin
            if (free_valid[j]) begin
                fi = free_idx[j*LG_N +: LG_N];
                if (w_freemask[fi])                  w_err_evt = 1'b1;
                if (r_bitmap[fi] && !w_popmask[fi])  w_err_evt = 1'b1;
                w_freemask[fi] = 1'b1;
            end
        end
        w_next     = (r_bitmap & ~w_popmask) | w_freemask;
        w_next_cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_next_cnt = w_next_cnt + (LG_N+1)'(w_next[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitmap <= RESET_MAP;
            r_count  <= RESET_CNT;
            r_err    <= 1'b0;
        end else begin
            r_bitmap <= w_next;
            r_count  <= w_next_cnt;
            r_err    <= r_err | w_err_evt;
        end
    end

endmodule

// File: tb/tb_ffs_free_list.sv
module tb_ffs_free_list;

    localparam int LG_N = 4;
    localparam int NA   = 2;
    localparam int NF   = 2;
    localparam int NRES = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NA-1:0] alloc_valid;
    logic [NA*LG_N-1:0] alloc_idx;
    logic [NA-1:0] alloc_pop = '0;
    logic [NF-1:0] free_valid = '0;
    logic [NF*LG_N-1:0] free_idx = '0;
    logic [LG_N:0] free_count;
    logic          empty;
    logic          err;

    int errors = 0;
    int checks = 0;

    ffs_free_list #(.LG_N(LG_N), .NUM_ALLOC(NA), .NUM_FREE(NF), .NUM_RESERVED(NRES)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_pop(alloc_pop),
        .free_valid(free_valid), .free_idx(free_idx),
        .free_count(free_count), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_pop  = '0;
        free_valid = '0;
        free_idx   = '0;
    endtask

    // Reset is asserted between edges. The state must appear without any
    // clock edge, because the reset is asynchronous.
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        checks++; if (alloc_idx[3:0] !== 4'd8) begin errors++; $display("FAIL reset_idx0 got=%0d exp=8", alloc_idx[3:0]); end
        checks++; if (alloc_idx[7:4] !== 4'd9) begin errors++; $display("FAIL reset_idx1 got=%0d exp=9", alloc_idx[7:4]); end
        checks++; if (alloc_valid !== 2'b11) begin errors++; $display("FAIL reset_valid got=%b exp=11", alloc_valid); end
        checks++; if (free_count !== 5'd8) begin errors++; $display("FAIL reset_count got=%0d exp=8", free_count); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty got=%b exp=0", empty); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_drain();
        alloc_pop = 2'b11;
        for (int c = 0; c < 4; c++) begin
            checks++; if (alloc_idx[3:0] !== 4'(8 + 2*c)) begin errors++; $display("FAIL drain_idx0 c=%0d got=%0d exp=%0d", c, alloc_idx[3:0], 8 + 2*c); end
            checks++; if (alloc_idx[7:4] !== 4'(9 + 2*c)) begin errors++; $display("FAIL drain_idx1 c=%0d got=%0d exp=%0d", c, alloc_idx[7:4], 9 + 2*c); end
            step();
            checks++; if (free_count !== 5'(6 - 2*c)) begin errors++; $display("FAIL drain_count c=%0d got=%0d exp=%0d", c, free_count, 6 - 2*c); end
        end
        alloc_pop = 2'b00;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
        checks++; if (alloc_valid !== 2'b00) begin errors++; $display("FAIL drain_valid got=%b exp=00", alloc_valid); end
        checks++; if (alloc_idx !== 8'h00) begin errors++; $display("FAIL drain_idx got=%h exp=00", alloc_idx); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL drain_err got=%b exp=0", err); end
    endtask

    // Starts from the empty state that test_drain leaves behind.
    task automatic test_free_pair();
        free_valid = 2'b11;
        free_idx   = {4'd3, 4'd5};
        checks++; if (alloc_valid !== 2'b00) begin errors++; $display("FAIL free_same_cycle got=%b exp=00", alloc_valid); end
        step();
        idle_inputs();
        checks++; if (alloc_idx !== {4'd5, 4'd3}) begin errors++; $display("FAIL free_offer got=%h exp=53", alloc_idx); end
        checks++; if (free_count !== 5'd2) begin errors++; $display("FAIL free_count got=%0d exp=2", free_count); end
        checks++; if (alloc_valid !== 2'b11) begin errors++; $display("FAIL free_valid_out got=%b exp=11", alloc_valid); end
        alloc_pop = 2'b10;
        step();
        idle_inputs();
        checks++; if (alloc_idx !== {4'd0, 4'd3}) begin errors++; $display("FAIL pop1_offer got=%h exp=03", alloc_idx); end
        checks++; if (alloc_valid !== 2'b01) begin errors++; $display("FAIL pop1_valid got=%b exp=01", alloc_valid); end
        checks++; if (free_count !== 5'd1) begin errors++; $display("FAIL pop1_count got=%0d exp=1", free_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL pop1_err got=%b exp=0", err); end
    endtask

    task automatic test_pop_free_same();
        test_reset();
        alloc_pop  = 2'b01;
        free_valid = 2'b01;
        free_idx   = {4'd0, 4'd8};
        step();
        idle_inputs();
        checks++; if (alloc_idx !== {4'd9, 4'd8}) begin errors++; $display("FAIL popfree_offer got=%h exp=98", alloc_idx); end
        checks++; if (free_count !== 5'd8) begin errors++; $display("FAIL popfree_count got=%0d exp=8", free_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL popfree_err got=%b exp=0", err); end
    endtask

    task automatic test_errors();
        test_reset();
        free_valid = 2'b01;
        free_idx   = {4'd0, 4'd12};
        step();
        idle_inputs();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL dblfree_err got=%b exp=1", err); end
        checks++; if (free_count !== 5'd8) begin errors++; $display("FAIL dblfree_count got=%0d exp=8", free_count); end
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL dblfree_sticky got=%b exp=1", err); end
        // Two ports returning the same reserved index: the count is exact and err is set.
        test_reset();
        free_valid = 2'b11;
        free_idx   = {4'd3, 4'd3};
        step();
        idle_inputs();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL dupfree_err got=%b exp=1", err); end
        checks++; if (free_count !== 5'd9) begin errors++; $display("FAIL dupfree_count got=%0d exp=9", free_count); end
        checks++; if (alloc_idx !== {4'd8, 4'd3}) begin errors++; $display("FAIL dupfree_offer got=%h exp=83", alloc_idx); end
        // A pop on an invalid port from the empty state.
        test_reset();
        alloc_pop = 2'b11;
        for (int c = 0; c < 4; c++) step();
        alloc_pop = 2'b01;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL empty_pre_err got=%b exp=0", err); end
        step();
        idle_inputs();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL badpop_err got=%b exp=1", err); end
        checks++; if (free_count !== 5'd0) begin errors++; $display("FAIL badpop_count got=%0d exp=0", free_count); end
        checks++; if (alloc_valid !== 2'b00) begin errors++; $display("FAIL badpop_valid got=%b exp=00", alloc_valid); end
    endtask

    task automatic test_random();
        logic [15:0] m;
        logic [15:0] nm;
        logic [15:0] popped;
        logic        me;
        int          nv;
        logic [3:0]  o0, o1, f0, f1;
        logic [1:0]  pop, fv;
        logic [7:0]  exp_idx;
        logic [1:0]  exp_valid;
        test_reset();
        m  = 16'hFF00;
        me = 1'b0;
        for (int c = 0; c < 80; c++) begin
            nv = 0; o0 = 4'd0; o1 = 4'd0;
            for (int i = 0; i < 16; i++) begin
                if (m[i]) begin
                    if (nv == 0) o0 = 4'(i);
                    else if (nv == 1) o1 = 4'(i);
                    nv++;
                end
            end
            exp_valid = {(nv >= 2), (nv >= 1)};
            exp_idx   = {o1, o0};
            checks++; if (alloc_idx !== exp_idx) begin errors++; $display("FAIL rnd_idx c=%0d got=%h exp=%h", c, alloc_idx, exp_idx); end
            checks++; if (alloc_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, alloc_valid, exp_valid); end
            checks++; if (free_count !== 5'($countones(m))) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, free_count, $countones(m)); end
            checks++; if (err !== me) begin errors++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err, me); end

            pop = 2'($urandom_range(0, 3));
            fv  = 2'b00;
            if ($urandom_range(0, 3) == 0) fv[0] = 1'b1;
            if ($urandom_range(0, 3) == 0) fv[1] = 1'b1;
            f0 = 4'($urandom_range(0, 15));
            f1 = 4'($urandom_range(0, 15));
            alloc_pop  = pop;
            free_valid = fv;
            free_idx   = {f1, f0};

            if (c == 30 || c == 55) begin
                // Reset discards everything driven this cycle.
                reset = 1'b1;
                step();
                reset = 1'b0;
                m  = 16'hFF00;
                me = 1'b0;
                continue;
            end

            popped = '0;
            if (pop[0]) begin if (nv >= 1) popped[o0] = 1'b1; else me = 1'b1; end
            if (pop[1]) begin if (nv >= 2) popped[o1] = 1'b1; else me = 1'b1; end
            nm = m & ~popped;
            if (fv[0]) begin
                if (m[f0] && !popped[f0]) me = 1'b1;
                nm[f0] = 1'b1;
            end
            if (fv[1]) begin
                if (m[f1] && !popped[f1]) me = 1'b1;
                if (fv[0] && (f0 == f1)) me = 1'b1;
                nm[f1] = 1'b1;
            end
            step();
            m = nm;
        end
        idle_inputs();
    endtask

    initial begin
        #1;
        test_reset();
        test_drain();
        test_free_pair();
        test_pop_free_same();
        test_errors();
        test_random();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
